// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional two-entry skid buffer.
// Carries a control bundle, NUM_DATA data words and a destination index between stages.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W   = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_DATA = 2,
  parameter int unsigned DEST_W   = 5,
  parameter int unsigned SKID     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0]          in_dest,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [DEST_W-1:0]          out_dest,
  output logic [1:0]                 occupancy
);

  localparam int unsigned DataBusW = NUM_DATA * DATA_W;

  typedef struct packed {
    logic [CTRL_W-1:0]   ctrl;
    logic [DataBusW-1:0] data;
    logic [DEST_W-1:0]   dest;
  } entryT;

  entryT mainEntry;
  entryT skidEntry;
  entryT inEntry;
  logic  mainValid;
  logic  skidValid;
  logic  mainFree;
  logic  doAccept;

  // With the skid buffer, in_ready depends only on state, never on out_ready.
  always_comb begin
    inEntry  = '{ctrl: in_ctrl, data: in_data, dest: in_dest};
    mainFree = !mainValid || out_ready;
    in_ready = (SKID != 0) ? !skidValid : mainFree;
    doAccept = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainEntry <= '0;
      skidEntry <= '0;
    end else if (flush) begin
      // Ctrl is cleared so a bubble never carries RegWrite/MemToReg downstream.
      mainValid      <= 1'b0;
      skidValid      <= 1'b0;
      mainEntry.ctrl <= '0;
      skidEntry.ctrl <= '0;
    end else if (mainFree) begin
      if (skidValid) begin
        mainValid      <= 1'b1;
        mainEntry      <= skidEntry;
        skidValid      <= 1'b0;
        skidEntry.ctrl <= '0;
      end else if (doAccept) begin
        mainValid <= 1'b1;
        mainEntry <= inEntry;
      end else begin
        mainValid      <= 1'b0;
        mainEntry.ctrl <= '0;
      end
    end else if (doAccept && (SKID != 0)) begin
      skidValid <= 1'b1;
      skidEntry <= inEntry;
    end
  end

  always_comb begin
    out_valid = mainValid;
    out_ctrl  = mainEntry.ctrl;
    out_data  = mainEntry.data;
    out_dest  = mainEntry.dest;
    occupancy = 2'(mainValid) + 2'(skidValid);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg (SKID=1 defaults) plus a
// scoreboarded random run of a SKID=0, 3x16-bit instance.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, inValid, outReady;
  logic [1:0] inCtrl;
  logic [63:0] inData;
  logic [4:0] inDest;
  logic inReady, outValid;
  logic [1:0] outCtrl, occ;
  logic [63:0] outData;
  logic [4:0] outDest;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData), .in_dest(inDest),
    .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
    .out_dest(outDest), .occupancy(occ)
  );

  logic flush1, inValid1, outReady1;
  logic [1:0] inCtrl1;
  logic [47:0] inData1;
  logic [4:0] inDest1;
  logic inReady1, outValid1;
  logic [1:0] outCtrl1, occ1;
  logic [47:0] outData1;
  logic [4:0] outDest1;

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(16), .NUM_DATA(3), .DEST_W(5), .SKID(0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(inValid1), .in_ready(inReady1), .in_ctrl(inCtrl1), .in_data(inData1), .in_dest(inDest1),
    .out_valid(outValid1), .out_ready(outReady1), .out_ctrl(outCtrl1), .out_data(outData1),
    .out_dest(outDest1), .occupancy(occ1)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ALURes in word 1, MemRes in word 0
  function automatic logic [63:0] mk(input logic [31:0] v);
    return {v, ~v};
  endfunction

  typedef struct {
    logic        fl;
    logic        iv;
    logic [1:0]  c;
    logic [31:0] v;
    logic [4:0]  d;
    logic        ordy;
    logic        eOv;
    logic [1:0]  eC;
    logic [31:0] eV;
    logic [4:0]  eD;
    logic [1:0]  eOcc;
    logic        eIr;
    logic        chkPay;
  } vecT;

  function automatic vecT mv(input logic fl, input logic iv, input logic [1:0] c,
                             input logic [31:0] v, input logic [4:0] d, input logic ordy,
                             input logic eOv, input logic [1:0] eC, input logic [31:0] eV,
                             input logic [4:0] eD, input logic [1:0] eOcc, input logic eIr,
                             input logic chkPay);
    vecT r;
    r.fl = fl; r.iv = iv; r.c = c; r.v = v; r.d = d; r.ordy = ordy;
    r.eOv = eOv; r.eC = eC; r.eV = eV; r.eD = eD; r.eOcc = eOcc; r.eIr = eIr; r.chkPay = chkPay;
    return r;
  endfunction

  vecT tbl[18];
  logic [54:0] sb[$];
  logic [54:0] got;

  initial begin
    // streaming, out_ready=1
    tbl[0]  = mv(0, 1, 2'd1, 32'h10, 5'd1, 1,  1, 2'd1, 32'h10, 5'd1, 2'd1, 1, 1);
    tbl[1]  = mv(0, 1, 2'd2, 32'h11, 5'd2, 1,  1, 2'd2, 32'h11, 5'd2, 2'd1, 1, 1);
    tbl[2]  = mv(0, 1, 2'd3, 32'h12, 5'd3, 1,  1, 2'd3, 32'h12, 5'd3, 2'd1, 1, 1);
    tbl[3]  = mv(0, 1, 2'd1, 32'h13, 5'd4, 1,  1, 2'd1, 32'h13, 5'd4, 2'd1, 1, 1);
    tbl[4]  = mv(0, 0, 2'd0, 32'h0,  5'd0, 1,  0, 2'd0, 32'h0,  5'd0, 2'd0, 1, 0);
    // back-pressure into skid, then drain
    tbl[5]  = mv(0, 1, 2'd3, 32'hA,  5'd5, 0,  1, 2'd3, 32'hA,  5'd5, 2'd1, 1, 1);
    tbl[6]  = mv(0, 1, 2'd2, 32'hB,  5'd6, 0,  1, 2'd3, 32'hA,  5'd5, 2'd2, 0, 1);
    tbl[7]  = mv(0, 1, 2'd1, 32'hC,  5'd7, 0,  1, 2'd3, 32'hA,  5'd5, 2'd2, 0, 1);
    tbl[8]  = mv(0, 0, 2'd0, 32'h0,  5'd0, 1,  1, 2'd2, 32'hB,  5'd6, 2'd1, 1, 1);
    tbl[9]  = mv(0, 0, 2'd0, 32'h0,  5'd0, 1,  0, 2'd0, 32'h0,  5'd0, 2'd0, 1, 0);
    // flush with occupancy=2 and in_valid=1
    tbl[10] = mv(0, 1, 2'd3, 32'hD,  5'd8, 0,  1, 2'd3, 32'hD,  5'd8, 2'd1, 1, 1);
    tbl[11] = mv(0, 1, 2'd3, 32'hE,  5'd9, 0,  1, 2'd3, 32'hD,  5'd8, 2'd2, 0, 1);
    tbl[12] = mv(1, 1, 2'd3, 32'hF,  5'd10, 0, 0, 2'd0, 32'h0,  5'd0, 2'd0, 1, 0);
    tbl[13] = mv(0, 0, 2'd0, 32'h0,  5'd0, 1,  0, 2'd0, 32'h0,  5'd0, 2'd0, 1, 0);
    // flush together with out_ready=1
    tbl[14] = mv(0, 1, 2'd1, 32'h20, 5'd11, 0, 1, 2'd1, 32'h20, 5'd11, 2'd1, 1, 1);
    tbl[15] = mv(1, 0, 2'd0, 32'h0,  5'd0, 1,  0, 2'd0, 32'h0,  5'd0, 2'd0, 1, 0);
    tbl[16] = mv(0, 1, 2'd2, 32'h21, 5'd12, 1, 1, 2'd2, 32'h21, 5'd12, 2'd1, 1, 1);
    tbl[17] = mv(0, 0, 2'd0, 32'h0,  5'd0, 1,  0, 2'd0, 32'h0,  5'd0, 2'd0, 1, 0);

    rst = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inCtrl = '0; inData = '0; inDest = '0;
    flush1 = 1'b0; inValid1 = 1'b0; outReady1 = 1'b0;
    inCtrl1 = '0; inData1 = '0; inDest1 = '0;
    tick; tick;
    chk("reset out_valid", 64'(outValid), 64'd0);
    chk("reset out_ctrl", 64'(outCtrl), 64'd0);
    chk("reset out_data", outData, 64'd0);
    chk("reset out_dest", 64'(outDest), 64'd0);
    chk("reset occupancy", 64'(occ), 64'd0);
    rst = 1'b1;
    tick;
    chk("post-reset in_ready", 64'(inReady), 64'd1);

    // bubble masking
    for (int i = 0; i < 10; i++) begin
      outReady = i[0];
      tick;
      chk($sformatf("bubble[%0d] out_valid", i), 64'(outValid), 64'd0);
      chk($sformatf("bubble[%0d] out_ctrl", i), 64'(outCtrl), 64'd0);
    end

    for (int i = 0; i < 18; i++) begin
      flush = tbl[i].fl; inValid = tbl[i].iv; inCtrl = tbl[i].c;
      inData = mk(tbl[i].v); inDest = tbl[i].d; outReady = tbl[i].ordy;
      tick;
      chk($sformatf("vec[%0d] out_valid", i), 64'(outValid), 64'(tbl[i].eOv));
      chk($sformatf("vec[%0d] out_ctrl", i), 64'(outCtrl), 64'(tbl[i].eC));
      chk($sformatf("vec[%0d] occupancy", i), 64'(occ), 64'(tbl[i].eOcc));
      chk($sformatf("vec[%0d] in_ready", i), 64'(inReady), 64'(tbl[i].eIr));
      if (tbl[i].chkPay) begin
        chk($sformatf("vec[%0d] out_data", i), outData, mk(tbl[i].eV));
        chk($sformatf("vec[%0d] out_dest", i), 64'(outDest), 64'(tbl[i].eD));
      end
    end
    flush = 1'b0;

    // reset in the middle of a full stall
    inValid = 1'b1; inCtrl = 2'd3; inData = mk(32'h30); inDest = 5'd13; outReady = 1'b0;
    tick;
    inData = mk(32'h31); inDest = 5'd14;
    tick;
    chk("stall occupancy", 64'(occ), 64'd2);
    chk("stall in_ready", 64'(inReady), 64'd0);
    rst = 1'b0; outReady = 1'b1;
    tick;
    chk("midrst out_valid", 64'(outValid), 64'd0);
    chk("midrst out_ctrl", 64'(outCtrl), 64'd0);
    chk("midrst out_data", outData, 64'd0);
    chk("midrst out_dest", 64'(outDest), 64'd0);
    chk("midrst occupancy", 64'(occ), 64'd0);
    rst = 1'b1; inValid = 1'b0;
    tick;
    chk("after midrst in_ready", 64'(inReady), 64'd1);
    chk("after midrst out_valid", 64'(outValid), 64'd0);

    // SKID=0 random run against a one-deep scoreboard
    for (int i = 0; i < 1010; i++) begin
      logic expIr;
      inValid1  = (i < 1000) ? ($urandom_range(0, 9) < 6) : 1'b0;
      outReady1 = (i < 1000) ? ($urandom_range(0, 9) < 6) : 1'b1;
      inCtrl1   = 2'($urandom);
      inData1   = 48'({$urandom, $urandom});
      inDest1   = 5'($urandom);
      #1;
      expIr = (sb.size() == 0) || outReady1;
      chk($sformatf("rnd[%0d] in_ready", i), 64'(inReady1), 64'(expIr));
      chk($sformatf("rnd[%0d] out_valid", i), 64'(outValid1), 64'(sb.size() != 0));
      chk($sformatf("rnd[%0d] occupancy", i), 64'(occ1), 64'(sb.size()));
      if (sb.size() != 0 && outReady1) begin
        got = {outCtrl1, outData1, outDest1};
        chk($sformatf("rnd[%0d] payload", i), 64'(got), 64'(sb.pop_front()));
      end else if (sb.size() == 0) begin
        chk($sformatf("rnd[%0d] bubble ctrl", i), 64'(outCtrl1), 64'd0);
      end
      if (inValid1 && expIr) sb.push_back({inCtrl1, inData1, inDest1});
      tick;
    end
    chk("rnd drained out_valid", 64'(outValid1), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register: the general successor to the fixed MEM/WB-style latch. It carries a control bundle, NUM_DATA data words and a destination-register index between two pipeline stages. It adds valid/ready handshaking, an optional two-entry skid buffer so upstream ready is a pure register output, and a synchronous flush that inserts a bubble. One instance is used for each inter-stage boundary (IF/ID through MEM/WB).

## Interface
- CTRL_W, 2: width of control bundle (e.g. MemToReg, RegWrite).
- DATA_W, 32: width of each data word.
- NUM_DATA, 2: number of data words carried (e.g. MemRes, ALURes).
- DEST_W, 5: width of destination register index.
- SKID, 1: 1 = two-entry skid buffer, registered in_ready; 0 = single entry, combinational in_ready.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discard all held entries; insert a bubble.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  NUM_DATA*DATA_W  data words; word k occupies bits [k*DATA_W +: DATA_W].
- in_dest  in  DEST_W  destination register index.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_ctrl  out  CTRL_W  control bundle, forced to 0 whenever out_valid=0.
- out_data  out  NUM_DATA*DATA_W  data words.
- out_dest  out  DEST_W  destination index.
- occupancy  out  2  number of valid entries held (0..2; never exceeds 1 when SKID=0).

## Operation
- Storage: main entry (drives outputs) plus, if SKID=1, one skid entry. Each entry holds valid, ctrl, data and dest.
- Accept: in_valid & in_ready. Release: out_valid & out_ready.
- SKID=1 behaviour:
  - in_ready = !skid_valid. It is a register output with no combinational path from out_ready.
  - Accept with main empty, or main releasing this cycle with skid empty: the entry loads into main.
  - Accept while main is held (out_valid & !out_ready): the entry loads into skid.
  - Main releasing with skid full: skid moves into main and skid clears. No accept is possible that cycle because in_ready=0.
- SKID=0 behaviour: in_ready = !out_valid | out_ready. On accept the entry loads into main.
- Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush or reset.
- Flush:
  - On the next edge, both valid bits and all stored ctrl fields clear.
  - Any accept in the flush cycle is discarded.
  - Data and dest fields may retain stale values.
  - out_ctrl is 0 from the cycle after flush, so no RegWrite or MemToReg reaches the next stage.
- Precedence: rst over flush over normal flow.
- Stall: out_ready=0 holds out_* stable. Upstream back-pressure appears as in_ready=0 only once the skid entry fills.

## Timing
- Reset (rst=0 at an edge): out_valid=0, out_ctrl=0, out_data=0, out_dest=0, occupancy=0. Skid cleared and in_ready=1 from the cycle after reset.
- Latency: an entry accepted at edge N appears on out_* after edge N, provided main is empty or releasing at N.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- SKID=1: in_ready falls 1 cycle after the skid fills. It rises the cycle after the skid drains into main.
- Simultaneous flush and out_ready=1: the current output is treated as consumed. No new entry is present after the edge.
- Reset mid-stall: all entries are lost, and out_valid=0 after the edge regardless of out_ready.

## Test plan
- Streaming, SKID=1: out_ready=1; send 4 entries with ALURes word = 0x10..0x13 and dest = 1..4 back-to-back. Required: out_valid is high for 4 consecutive cycles starting 1 cycle after the first accept, order preserved, in_ready=1 throughout.
- Back-pressure: out_ready=0 with main holding 0xA. Send 0xB. Required: 0xB lands in skid, occupancy=2, in_ready=0 the next cycle, out_data stable at 0xA. Raise out_ready: required output 0xA then 0xB, and in_ready returns to 1.
- Flush: with occupancy=2 and ctrl=2'b11, assert flush together with in_valid=1. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, and the flushed input never appears.
- Bubble masking: after reset with no input, check out_ctrl=0 and out_valid=0 every cycle for 10 cycles, including with out_ready toggling.
- SKID=0 with DATA_W=16 and NUM_DATA=3: random in_valid/out_ready for 1000 cycles. Required: a scoreboard shows in-order delivery with no loss, occupancy<=1, and in_ready = !out_valid | out_ready every cycle.
- Reset mid-operation: pull rst low while occupancy=2 and out_ready=0. Required: all outputs 0 and occupancy=0 after the edge, then in_ready=1 after release.
